mont_trans_gen: RTL and testbench

Parametrised, bit-serial Montgomery-domain transform unit. It computes o_result = (i_a * 2^K) mod i_n for WIDTH-bit operands, or plain i_a mod i_n in reduce-only mode. It sits in front of the Montgomery multiplier in the RSA datapath and also serves as a generic modular pre-reducer.
- Unlike the fixed 256-bit transform, it accepts arbitrary i_a (not required < i_n).
- Its results are always fully reduced (0 <= result < n).
- It flags n == 0.

---
 rtl/mont_trans_gen.sv | 153 +++++++++++++++
 tb/tb_mont_trans_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_trans_gen.sv
// Bit-serial Montgomery-domain transform unit.
// Computes (a * 2^K) mod n, or plain a mod n in reduce-only mode, for any
// WIDTH-bit operand a and nonzero modulus n. First the operand is reduced
// one bit at a time, MSB first. In transform mode this is followed by K
// modular doublings. A zero modulus is reported through o_error.
module mont_trans_gen #(
  parameter int WIDTH = 256,
  parameter int K     = WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished,
  output logic             o_busy,
  output logic             o_error
);

  localparam int MAX_WK = (WIDTH > K) ? WIDTH : K;
  localparam int CNT_W  = $clog2(MAX_WK + 1);
  localparam logic [CNT_W-1:0] LAST_RED = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_SHF = CNT_W'(K - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             mode_q, mode_d;
  logic             zero_n_q, zero_n_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             finished_q, finished_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;
  logic [WIDTH:0]   t;

  // The running remainder stays below n, so t <= 2n-1 and one conditional
  // subtract fully reduces it. Using >= means a result equal to n cannot occur.
  function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH:0]   tv,
                                                input logic [WIDTH-1:0] nv);
    logic [WIDTH:0] diff;
    diff = tv - {1'b0, nv};
    if (tv >= {1'b0, nv}) return diff[WIDTH-1:0];
    return tv[WIDTH-1:0];
  endfunction

  // Next-state logic and datapath step for the serial reduction.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    n_d        = n_q;
    r_d        = r_q;
    mode_d     = mode_q;
    zero_n_d   = zero_n_q;
    result_d   = result_q;
    finished_d = 1'b0;
    error_d    = 1'b0;
    t          = '0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d      = i_a;
          n_d      = i_n;
          mode_d   = i_mode;
          r_d      = '0;
          cnt_d    = '0;
          result_d = '0;
          zero_n_d = (i_n == '0);
          state_d  = (i_n == '0) ? DONE : REDUCE;
        end
      end
      REDUCE: begin
        // Shift the next operand bit (MSB first) into the remainder.
        t   = {r_q, a_q[WIDTH-1]};
        r_d = cond_sub(t, n_q);
        a_d = a_q << 1;
        if (cnt_q == LAST_RED) begin
          cnt_d   = '0;
          state_d = mode_q ? DONE : SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        // Each step is one modular doubling.
        t   = {r_q, 1'b0};
        r_d = cond_sub(t, n_q);
        if (cnt_q == LAST_SHF) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Publish the result. It stays on o_result until the next accepted start.
        result_d   = r_q;
        finished_d = 1'b1;
        error_d    = zero_n_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, operand and output registers. Reset clears everything, including
  // any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      n_q        <= '0;
      r_q        <= '0;
      mode_q     <= 1'b0;
      zero_n_q   <= 1'b0;
      result_q   <= '0;
      finished_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      n_q        <= n_d;
      r_q        <= r_d;
      mode_q     <= mode_d;
      zero_n_q   <= zero_n_d;
      result_q   <= result_d;
      finished_q <= finished_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign o_result   = result_q;
  assign o_finished = finished_q;
  assign o_busy     = busy_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_mont_trans_gen.sv
// Testbench for mont_trans_gen: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_mont_trans_gen;

  localparam int W8 = 8;
  localparam int K8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Main instance: WIDTH=8, K=8
  logic          start8 = 1'b0, mode8 = 1'b0;
  logic [7:0]    a8 = '0, n8 = '0, res8;
  logic          fin8, busy8, err8;

  // WIDTH=8, K=1 instance
  logic          st_k = 1'b0, md_k = 1'b0;
  logic [7:0]    a_k = '0, n_k = '0, res_k;
  logic          fin_k, busy_k, err_k;

  // Default WIDTH=256 instance
  logic          st_b = 1'b0, md_b = 1'b0;
  logic [255:0]  a_b = '0, n_b = '0, res_b;
  logic          fin_b, busy_b, err_b;

  int checks = 0;
  int failures = 0;

  mont_trans_gen #(.WIDTH(W8), .K(K8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_mode(mode8),
    .i_a(a8), .i_n(n8), .o_result(res8), .o_finished(fin8),
    .o_busy(busy8), .o_error(err8));

  mont_trans_gen #(.WIDTH(8), .K(1)) dut_k1 (
    .i_clk(clk), .i_rst(rst), .i_start(st_k), .i_mode(md_k),
    .i_a(a_k), .i_n(n_k), .o_result(res_k), .o_finished(fin_k),
    .o_busy(busy_k), .o_error(err_k));

  mont_trans_gen dut_big (
    .i_clk(clk), .i_rst(rst), .i_start(st_b), .i_mode(md_b),
    .i_a(a_b), .i_n(n_b), .o_result(res_b), .o_finished(fin_b),
    .o_busy(busy_b), .o_error(err_b));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition
  function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] n, input logic m);
    longint p;
    if (n == 8'd0) return 8'd0;
    p = m ? longint'(a) : (longint'(a) << K8);
    return 8'(p % longint'(n));
  endfunction

  function automatic logic [255:0] ref256(input logic [255:0] a, input logic [255:0] n, input logic m);
    logic [511:0] p;
    if (n == '0) return '0;
    p = m ? {256'b0, a} : {a, 256'b0};
    p = p % {256'b0, n};
    return p[255:0];
  endfunction

  // Transaction-level model of the main instance: an accepted job completes a
  // fixed number of edges later; nothing new is accepted while a job is open.
  bit         m_active = 1'b0;
  int         m_left = 0;
  logic [7:0] m_exp = '0, m_res = '0;
  logic       m_eerr = 1'b0, m_fin = 1'b0, m_err = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 1'b0; m_left = 0; m_res = '0; m_fin = 1'b0; m_err = 1'b0;
      end else begin
        m_fin = 1'b0; m_err = 1'b0;
        if (!m_active) begin
          if (start8) begin
            m_active = 1'b1;
            m_exp    = ref8(a8, n8, mode8);
            m_eerr   = (n8 == 8'd0);
            m_left   = (n8 == 8'd0) ? 1 : (mode8 ? W8 + 1 : W8 + K8 + 1);
            m_res    = '0;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_active = 1'b0;
            m_fin    = 1'b1;
            m_err    = m_eerr;
            m_res    = m_exp;
          end
        end
      end
      #1;
      chk("cyc_finished", fin8, m_fin);
      chk("cyc_busy", busy8, m_active);
      chk("cyc_error", err8, m_err);
      chk("cyc_result", res8, m_res);
    end
  end

  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] n, input logic m,
                     input logic [7:0] er, input logic ee, input int el);
    int lat;
    bit got;
    @(negedge clk);
    start8 = 1'b1; a8 = a; n8 = n; mode8 = m;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; n8 = ~n;
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      got = fin8;
    end
    chk({nm, "_latency"}, lat, el);
    chk({nm, "_result"}, res8, er);
    chk({nm, "_error"}, err8, ee);
    @(posedge clk); #1;
    chk({nm, "_pulse_end"}, fin8, 1'b0);
    chk({nm, "_result_held"}, res8, er);
  endtask

  task automatic op_x(input string nm, input bit big, input logic [255:0] a, input logic [255:0] n,
                      input logic m, input logic [255:0] er, input int el);
    int lat;
    bit got;
    logic [255:0] r;
    @(negedge clk);
    if (big) begin st_b = 1'b1; a_b = a; n_b = n; md_b = m; end
    else begin st_k = 1'b1; a_k = a[7:0]; n_k = n[7:0]; md_k = m; end
    @(posedge clk);
    @(negedge clk);
    st_b = 1'b0; st_k = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      got = big ? fin_b : fin_k;
    end
    r = big ? res_b : {248'b0, res_k};
    chk({nm, "_latency"}, lat, el);
    chk({nm, "_result"}, r, er);
    chk({nm, "_error"}, big ? err_b : err_k, 1'b0);
  endtask

  initial begin
    int f1, f2, nfin, sel;
    logic [255:0] ra, rn;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_result", res8, 8'd0);
    chk("reset_finished", fin8, 1'b0);
    chk("reset_busy", busy8, 1'b0);
    chk("reset_error", err8, 1'b0);

    // Directed literal cases
    op8("t_5_13", 8'd5, 8'd13, 1'b0, 8'd6, 1'b0, 17);
    op8("r_200_13", 8'd200, 8'd13, 1'b1, 8'd5, 1'b0, 9);
    op8("t_255_255", 8'd255, 8'd255, 1'b0, 8'd0, 1'b0, 17);
    op8("n_zero", 8'd77, 8'd0, 1'b0, 8'd0, 1'b1, 1);
    op8("n_one", 8'hFF, 8'd1, 1'b0, 8'd0, 1'b0, 17);
    op8("r_a_lt_n", 8'd12, 8'd13, 1'b1, 8'd12, 1'b0, 9);

    // Start held high while the operand keeps changing
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd5; n8 = 8'd13; mode8 = 1'b0;
    f1 = -1; f2 = -1;
    for (int e = 0; e < 36; e++) begin
      @(posedge clk); #1;
      if (fin8) begin
        if (f1 < 0) begin f1 = e; chk("held_first_result", res8, 8'd6); end
        else if (f2 < 0) f2 = e;
      end
      @(negedge clk);
      a8 = a8 ^ 8'hA5;
      if (e == 35) start8 = 1'b0;
    end
    chk("held_first_done_edge", f1, 17);
    chk("held_second_done_edge", f2, 35);

    // Reset in the middle of a run
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd99; n8 = 8'd31; mode8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy8, 1'b0);
    chk("midrst_finished", fin8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    nfin = 0;
    repeat (30) begin @(posedge clk); #1; if (fin8) nfin++; end
    chk("midrst_no_done", nfin, 0);
    op8("after_rst", 8'd99, 8'd31, 1'b0, ref8(8'd99, 8'd31, 1'b0), 1'b0, 17);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 299) == 0);
      start8 = ($urandom_range(0, 3) == 0);
      a8     = 8'($urandom);
      sel    = int'($urandom_range(0, 7));
      n8     = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : 8'($urandom);
      mode8  = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    repeat (30) @(negedge clk);

    // K=1 instance: 24 mod 13 exercises the >= compare path
    op_x("k1_12_13", 1'b0, 256'd12, 256'd13, 1'b0, 256'd11, 10);

    // WIDTH=256 instance
    op_x("w256_one", 1'b1, 256'd1, {256{1'b1}}, 1'b0, 256'd1, 513);
    rn = {1'b1, 255'b0} + 256'd1;
    op_x("w256_three", 1'b1, 256'd3, rn, 1'b0, rn - 256'd6, 513);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 8; j++) begin
        ra[j*32 +: 32] = $urandom;
        rn[j*32 +: 32] = $urandom;
      end
      rn[0] = rn[0] | (i == 0);
      op_x("w256_rand", 1'b1, ra, rn, i[0], ref256(ra, rn, i[0]), i[0] ? 257 : 513);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
